sad_pe_col: RTL and testbench

Parametrised column of processing elements for the inter-prediction motion-estimation array. It holds one column of current-block (CPR) and search-window (SPR) pixels and computes per-row absolute differences. Each register chain can shift down or up, which supports snake-scan search. An on-column accumulator with a small FSM produces a complete column SAD over BLK_DIM shift steps. Columns are tiled side by side inside the ME array, and the SAD outputs feed the array-level adder/compare stage.

---
 rtl/me_pkg.sv | 18 +
 rtl/pe_dir.sv | 67 ++++++
 rtl/sad_pe_col.sv | 198 +++++++++++++++++++
 tb/tb_sad_pe_col.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/me_pkg.sv
// Shared motion-estimation package.
// Provides the column accumulator FSM state type and the SAD width helper.
// The array-level comparator uses the same definitions.
package me_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } me_state_e;

    // Width that holds blk_dim * blk_dim * (2^pix_w - 1) without overflow.
    function automatic int unsigned sad_width(input int unsigned blk_dim,
                                              input int unsigned pix_w);
        return pix_w + 2 * $clog2(blk_dim);
    endfunction

endpackage

// File: rtl/pe_dir.sv
// One processing element of the SAD column.
// It holds one SPR and one CPR pixel, each register fed through a 2:1
// direction mux, and a registered absolute difference of the two pixels.
// Ports:
//   clk, rst_n                  clock, async active-low reset
//   en_spr_i / en_cpr_i         shift enable of each chain
//   shift_dir_i                 0 = take from the PE above, 1 = take from the PE below
//   spr_prev_i / spr_next_i     SPR pixel from the PE above / below
//   cpr_prev_i / cpr_next_i     CPR pixel from the PE above / below
//   ad_en_i                     load the absolute-difference register
//   spr_o / cpr_o               chain registers
//   ad_o                        absolute-difference register
module pe_dir #(
    parameter int unsigned PIX_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en_spr_i,
    input  logic             en_cpr_i,
    input  logic             shift_dir_i,
    input  logic [PIX_W-1:0] spr_prev_i,
    input  logic [PIX_W-1:0] spr_next_i,
    input  logic [PIX_W-1:0] cpr_prev_i,
    input  logic [PIX_W-1:0] cpr_next_i,
    input  logic             ad_en_i,
    output logic [PIX_W-1:0] spr_o,
    output logic [PIX_W-1:0] cpr_o,
    output logic [PIX_W-1:0] ad_o
);

    logic [PIX_W-1:0] spr_d, spr_q;
    logic [PIX_W-1:0] cpr_d, cpr_q;
    logic [PIX_W-1:0] ad_d, ad_q;

    always_comb begin
        spr_d = spr_q;
        cpr_d = cpr_q;
        ad_d  = ad_q;
        if (en_spr_i) begin
            spr_d = shift_dir_i ? spr_next_i : spr_prev_i;
        end
        if (en_cpr_i) begin
            cpr_d = shift_dir_i ? cpr_next_i : cpr_prev_i;
        end
        // Subtract the smaller from the larger so the result never wraps.
        if (ad_en_i) begin
            ad_d = (spr_q >= cpr_q) ? (spr_q - cpr_q) : (cpr_q - spr_q);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            spr_q <= '0;
            cpr_q <= '0;
            ad_q  <= '0;
        end else begin
            spr_q <= spr_d;
            cpr_q <= cpr_d;
            ad_q  <= ad_d;
        end
    end

    assign spr_o = spr_q;
    assign cpr_o = cpr_q;
    assign ad_o  = ad_q;

endmodule

// File: rtl/sad_pe_col.sv
// Column of BLK_DIM processing elements for the motion-estimation array.
// Shifts CPR and SPR pixel chains up or down, registers per-row absolute
// differences, sums them into a column sum and accumulates BLK_DIM column
// sums into a column SAD under control of a three-state FSM.
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   start                      begin a new accumulation (ignored while busy)
//   en_spr / en_cpr            shift the SPR / CPR chain one position
//   shift_dir                  0 = down, 1 = up (applies to both chains)
//   spr_in / spr_up_in         SPR pixel entering at top / bottom
//   cpr_in / cpr_up_in         CPR pixel entering at top / bottom
//   spr_out / cpr_out          last PE of each chain, feeds the next column
//   ad                         packed absolute differences, PE i in lane i
//   sad                        column SAD, held until the next completion
//   sad_valid                  one-cycle pulse when sad is updated
//   busy                       high while accumulating
module sad_pe_col
    import me_pkg::*;
#(
    parameter int unsigned BLK_DIM = 16,
    parameter int unsigned PIX_W   = 8,
    parameter int unsigned SAD_W   = sad_width(BLK_DIM, PIX_W)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic                     en_spr,
    input  logic                     en_cpr,
    input  logic                     shift_dir,
    input  logic [PIX_W-1:0]         spr_in,
    input  logic [PIX_W-1:0]         spr_up_in,
    input  logic [PIX_W-1:0]         cpr_in,
    input  logic [PIX_W-1:0]         cpr_up_in,
    output logic [PIX_W-1:0]         spr_out,
    output logic [PIX_W-1:0]         cpr_out,
    output logic [BLK_DIM*PIX_W-1:0] ad,
    output logic [SAD_W-1:0]         sad,
    output logic                     sad_valid,
    output logic                     busy
);

    localparam int unsigned COL_W  = PIX_W + $clog2(BLK_DIM);
    localparam int unsigned STEP_W = $clog2(BLK_DIM);
    localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(BLK_DIM - 1);

    logic [PIX_W-1:0] spr_chain [BLK_DIM];
    logic [PIX_W-1:0] cpr_chain [BLK_DIM];
    logic [PIX_W-1:0] ad_lane   [BLK_DIM];

    logic pe_v_d, pe_v_q;
    logic ad_v_d, ad_v_q;

    // ------------------------------------------------------------------
    // PE chain
    // ------------------------------------------------------------------
    for (genvar i = 0; i < int'(BLK_DIM); i++) begin : g_pe
        logic [PIX_W-1:0] spr_prev, spr_next, cpr_prev, cpr_next;

        if (i == 0) begin : g_first
            assign spr_prev = spr_in;
            assign cpr_prev = cpr_in;
        end else begin : g_inner_prev
            assign spr_prev = spr_chain[i-1];
            assign cpr_prev = cpr_chain[i-1];
        end

        if (i == int'(BLK_DIM) - 1) begin : g_last
            assign spr_next = spr_up_in;
            assign cpr_next = cpr_up_in;
        end else begin : g_inner_next
            assign spr_next = spr_chain[i+1];
            assign cpr_next = cpr_chain[i+1];
        end

        pe_dir #(
            .PIX_W (PIX_W)
        ) u_pe (
            .clk         (clk),
            .rst_n       (rst_n),
            .en_spr_i    (en_spr),
            .en_cpr_i    (en_cpr),
            .shift_dir_i (shift_dir),
            .spr_prev_i  (spr_prev),
            .spr_next_i  (spr_next),
            .cpr_prev_i  (cpr_prev),
            .cpr_next_i  (cpr_next),
            .ad_en_i     (pe_v_q),
            .spr_o       (spr_chain[i]),
            .cpr_o       (cpr_chain[i]),
            .ad_o        (ad_lane[i])
        );

        assign ad[PIX_W*i +: PIX_W] = ad_lane[i];
    end

    assign spr_out = spr_chain[BLK_DIM-1];
    assign cpr_out = cpr_chain[BLK_DIM-1];

    // ------------------------------------------------------------------
    // Valid pipeline: a shift makes the chains new, the next edge loads ad,
    // the edge after that may accumulate it.
    // ------------------------------------------------------------------
    assign pe_v_d = en_spr | en_cpr;
    assign ad_v_d = pe_v_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pe_v_q <= 1'b0;
            ad_v_q <= 1'b0;
        end else begin
            pe_v_q <= pe_v_d;
            ad_v_q <= ad_v_d;
        end
    end

    // ------------------------------------------------------------------
    // Column sum
    // ------------------------------------------------------------------
    logic [COL_W-1:0] colsum;

    always_comb begin
        colsum = '0;
        for (int i = 0; i < int'(BLK_DIM); i++) begin
            colsum = colsum + COL_W'(ad_lane[i]);
        end
    end

    // ------------------------------------------------------------------
    // Accumulator FSM
    // ------------------------------------------------------------------
    me_state_e         state_d, state_q;
    logic [SAD_W-1:0]  acc_d, acc_q;
    logic [STEP_W-1:0] step_d, step_q;
    logic [SAD_W-1:0]  sad_d, sad_q;
    logic [SAD_W-1:0]  acc_sum;

    assign acc_sum = acc_q + SAD_W'(colsum);

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        step_d  = step_q;
        sad_d   = sad_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    acc_d   = '0;
                    step_d  = '0;
                    state_d = ACCUM;
                end
            end
            ACCUM: begin
                // start is deliberately ignored here.
                if (ad_v_q) begin
                    acc_d  = acc_sum;
                    step_d = step_q + STEP_W'(1);
                    if (step_q == STEP_LAST) begin
                        sad_d   = acc_sum;
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                // Back-to-back start restarts without a dead IDLE cycle;
                // sad keeps the value just completed.
                if (start) begin
                    acc_d   = '0;
                    step_d  = '0;
                    state_d = ACCUM;
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            acc_q   <= '0;
            step_q  <= '0;
            sad_q   <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            step_q  <= step_d;
            sad_q   <= sad_d;
        end
    end

    assign sad       = sad_q;
    assign sad_valid = (state_q == DONE);
    assign busy      = (state_q == ACCUM);

endmodule

// File: tb/tb_sad_pe_col.sv
// Self-checking bench for sad_pe_col (BLK_DIM = 4, PIX_W = 8).
// A behavioural model tracks the pixel columns, the delayed absolute
// differences and the SAD run, and every cycle is compared against it;
// directed scenarios additionally check hand-derived constants.
module tb_sad_pe_col;

    localparam int BLK = 4;
    localparam int PW  = 8;
    localparam int SW  = PW + 2 * $clog2(BLK);

    logic              clk;
    logic              rst_n;
    logic              start;
    logic              en_spr;
    logic              en_cpr;
    logic              shift_dir;
    logic [PW-1:0]     spr_in;
    logic [PW-1:0]     spr_up_in;
    logic [PW-1:0]     cpr_in;
    logic [PW-1:0]     cpr_up_in;
    logic [PW-1:0]     spr_out;
    logic [PW-1:0]     cpr_out;
    logic [BLK*PW-1:0] ad;
    logic [SW-1:0]     sad;
    logic              sad_valid;
    logic              busy;

    sad_pe_col #(
        .BLK_DIM (BLK),
        .PIX_W   (PW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .en_spr    (en_spr),
        .en_cpr    (en_cpr),
        .shift_dir (shift_dir),
        .spr_in    (spr_in),
        .spr_up_in (spr_up_in),
        .cpr_in    (cpr_in),
        .cpr_up_in (cpr_up_in),
        .spr_out   (spr_out),
        .cpr_out   (cpr_out),
        .ad        (ad),
        .sad       (sad),
        .sad_valid (sad_valid),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: pixel columns, per-row differences waiting to be
    // summed, and the SAD run (phase 0 idle, 1 running, 2 just finished).
    int m_spr [BLK];
    int m_cpr [BLK];
    int m_ad  [BLK];
    bit m_shifted;     // a chain moved on the last edge
    bit m_ad_new;      // ad was refreshed on the last edge
    int m_phase;
    int m_sum;
    int m_cnt;
    int m_sad;

    int pulses;
    int seen_sad;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < BLK; i++) begin
            m_spr[i] = 0;
            m_cpr[i] = 0;
            m_ad[i]  = 0;
        end
        m_shifted = 0;
        m_ad_new  = 0;
        m_phase   = 0;
        m_sum     = 0;
        m_cnt     = 0;
        m_sad     = 0;
    endtask

    function automatic logic [BLK*PW-1:0] model_ad_bus();
        logic [BLK*PW-1:0] v;
        v = '0;
        for (int i = 0; i < BLK; i++) v[PW*i +: PW] = PW'(m_ad[i]);
        return v;
    endfunction

    // Applies the behaviour of one rising edge to the model.
    task automatic model_edge(input bit st, input bit es, input bit ec, input bit dir,
                              input int si, input int su, input int ci, input int cu);
        int colsum;
        int tmp_s [BLK];
        int tmp_c [BLK];
        colsum = 0;
        for (int i = 0; i < BLK; i++) colsum += m_ad[i];

        // SAD run
        if (m_phase == 0) begin
            if (st) begin m_sum = 0; m_cnt = 0; m_phase = 1; end
        end else if (m_phase == 1) begin
            if (m_ad_new) begin
                m_sum += colsum;
                m_cnt++;
                if (m_cnt == BLK) begin m_sad = m_sum; m_phase = 2; end
            end
        end else begin
            if (st) begin m_sum = 0; m_cnt = 0; m_phase = 1; end
            else m_phase = 0;
        end

        // Differences are taken from the columns as they stood before this edge.
        if (m_shifted) begin
            for (int i = 0; i < BLK; i++) begin
                m_ad[i] = (m_spr[i] > m_cpr[i]) ? m_spr[i] - m_cpr[i] : m_cpr[i] - m_spr[i];
            end
        end
        m_ad_new  = m_shifted;
        m_shifted = es | ec;

        // Column shift: build the shifted columns, then commit.
        for (int i = 0; i < BLK; i++) begin
            if (dir) begin
                tmp_s[i] = (i == BLK - 1) ? su : m_spr[i+1];
                tmp_c[i] = (i == BLK - 1) ? cu : m_cpr[i+1];
            end else begin
                tmp_s[i] = (i == 0) ? si : m_spr[i-1];
                tmp_c[i] = (i == 0) ? ci : m_cpr[i-1];
            end
        end
        for (int i = 0; i < BLK; i++) begin
            if (es) m_spr[i] = tmp_s[i];
            if (ec) m_cpr[i] = tmp_c[i];
        end
    endtask

    task automatic compare_model();
        check("spr_out", 64'(spr_out), 64'(m_spr[BLK-1]));
        check("cpr_out", 64'(cpr_out), 64'(m_cpr[BLK-1]));
        check("ad", 64'(ad), 64'(model_ad_bus()));
        check("sad", 64'(sad), 64'(m_sad));
        check("sad_valid", 64'(sad_valid), 64'(m_phase == 2));
        check("busy", 64'(busy), 64'(m_phase == 1));
    endtask

    // One clock cycle: drive inputs, clock, update model, sample after the edge.
    task automatic tick(input bit st, input bit es, input bit ec, input bit dir,
                        input int si, input int su, input int ci, input int cu);
        start     = st;
        en_spr    = es;
        en_cpr    = ec;
        shift_dir = dir;
        spr_in    = PW'(si);
        spr_up_in = PW'(su);
        cpr_in    = PW'(ci);
        cpr_up_in = PW'(cu);
        @(posedge clk);
        model_edge(st, es, ec, dir, si, su, ci, cu);
        #1;
        compare_model();
        if (sad_valid) begin
            pulses++;
            seen_sad = int'(sad);
        end
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) tick(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic fill_down(input bit es, input bit ec, input int sv, input int cv);
        for (int k = 0; k < BLK; k++) tick(0, es, ec, 0, sv, 0, cv, 0);
    endtask

    // Bounded wait for completion; stop_on_valid leaves the DUT in DONE.
    task automatic wait_sad(input bit stop_on_valid);
        for (int k = 0; k < 10; k++) begin
            tick(0, 0, 0, 0, 0, 0, 0, 0);
            if (stop_on_valid && sad_valid) break;
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_spr_out"}, 64'(spr_out), 64'd0);
        check({tag, "_cpr_out"}, 64'(cpr_out), 64'd0);
        check({tag, "_ad"}, 64'(ad), 64'd0);
        check({tag, "_sad"}, 64'(sad), 64'd0);
        check({tag, "_sad_valid"}, 64'(sad_valid), 64'd0);
        check({tag, "_busy"}, 64'(busy), 64'd0);
    endtask

    initial begin
        rst_n     = 1'b0;
        start     = 1'b0;
        en_spr    = 1'b0;
        en_cpr    = 1'b0;
        shift_dir = 1'b0;
        spr_in    = '0;
        spr_up_in = '0;
        cpr_in    = '0;
        cpr_up_in = '0;
        model_reset();

        // Reset values
        #2;
        check_reset_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;
        idle(2);
        check_reset_outputs("post_reset");

        // Constant data, down shift: |30 - 10| = 20 per lane, 4 x 80 = 320
        fill_down(1, 1, 30, 10);
        idle(2);
        check("const_ad", 64'(ad), 64'h14141414);
        tick(1, 0, 0, 0, 0, 0, 0, 0);
        check("const_busy", 64'(busy), 64'd1);
        pulses = 0;
        for (int k = 0; k < BLK; k++) tick(0, 1, 0, 0, 30, 0, 0, 0);
        wait_sad(0);
        check("const_pulses", 64'(pulses), 64'd1);
        check("const_sad", 64'(seen_sad), 64'd320);

        // Direction: CPR cleared, then push 1..4 upwards
        fill_down(0, 1, 0, 0);
        for (int v = 1; v <= BLK; v++) tick(0, 1, 0, 1, 0, v, 0, 0);
        check("dir_up_spr_out", 64'(spr_out), 64'd4);
        idle(1);
        check("dir_up_ad", 64'(ad), 64'h04030201);
        tick(0, 1, 0, 0, 9, 0, 0, 0);
        check("dir_down_spr_out", 64'(spr_out), 64'd3);
        idle(1);
        check("dir_down_ad", 64'(ad), 64'h03020109);

        // Start while busy is ignored: SPR = 5, CPR = 0 -> 4 x 20 = 80
        fill_down(1, 0, 5, 0);
        idle(2);
        tick(1, 0, 0, 0, 0, 0, 0, 0);
        pulses = 0;
        tick(0, 1, 0, 0, 5, 0, 0, 0);
        tick(0, 1, 0, 0, 5, 0, 0, 0);
        tick(1, 1, 0, 0, 5, 0, 0, 0);
        tick(0, 1, 0, 0, 5, 0, 0, 0);
        wait_sad(1);
        check("busy_start_pulses", 64'(pulses), 64'd1);
        check("busy_start_sad", 64'(seen_sad), 64'd80);

        // Back-to-back start in DONE; pushing 9s gives 24+28+32+36 = 120
        tick(1, 0, 0, 0, 0, 0, 0, 0);
        check("b2b_busy", 64'(busy), 64'd1);
        check("b2b_sad_held", 64'(sad), 64'd80);
        pulses = 0;
        for (int k = 0; k < BLK; k++) tick(0, 1, 0, 0, 9, 0, 0, 0);
        wait_sad(0);
        check("b2b_pulses", 64'(pulses), 64'd1);
        check("b2b_sad", 64'(seen_sad), 64'd120);

        // Maximum values: 16 x 255 = 4080
        fill_down(1, 0, 255, 0);
        idle(2);
        tick(1, 0, 0, 0, 0, 0, 0, 0);
        pulses = 0;
        for (int k = 0; k < BLK; k++) tick(0, 1, 0, 0, 255, 0, 0, 0);
        wait_sad(0);
        check("max_pulses", 64'(pulses), 64'd1);
        check("max_sad", 64'(seen_sad), 64'd4080);

        // Reset mid-ACCUM, then a clean run: |8 - 3| x 16 = 80
        tick(1, 0, 0, 0, 0, 0, 0, 0);
        tick(0, 1, 0, 0, 100, 0, 0, 0);
        tick(0, 1, 0, 0, 100, 0, 0, 0);
        idle(2);
        check("mid_busy", 64'(busy), 64'd1);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_reset_outputs("mid_reset");
        @(negedge clk);
        rst_n = 1'b1;
        fill_down(1, 1, 8, 3);
        idle(2);
        tick(1, 0, 0, 0, 0, 0, 0, 0);
        pulses = 0;
        for (int k = 0; k < BLK; k++) tick(0, 1, 0, 0, 8, 0, 0, 0);
        wait_sad(0);
        check("rerun_pulses", 64'(pulses), 64'd1);
        check("rerun_sad", 64'(seen_sad), 64'd80);

        // Randomized traffic against the model
        for (int k = 0; k < 400; k++) begin
            tick(($urandom_range(0, 7) == 0), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
                 int'($urandom_range(0, 255)), int'($urandom_range(0, 255)));
        end
        idle(8);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
